// File: rtl/mem_access_unit.sv
// Stallable MIPS memory-access stage on an SRAM-like req/addr_ok/data_ok bus.
// Formats store data, extends load data, flags misalignment, supports flush and a watchdog.
module mem_access_unit #(
  parameter int CHECK_ALIGN = 1,
  parameter int MAX_WAIT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic        adel,
  output logic        ades,
  output logic        buserr,
  output logic [31:0] badvaddr,
  output logic [1:0]  dbg_state_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    op_q, op_d;
  logic [4:0]    rd_q, rd_d;
  logic          regwrite_q, regwrite_d;
  logic          data_req_q, data_req_d;
  logic          data_wr_q, data_wr_d;
  logic [1:0]    data_size_q, data_size_d;
  logic [31:0]   data_addr_q, data_addr_d;
  logic [31:0]   data_wdata_q, data_wdata_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_rdata_q, out_rdata_d;
  logic [4:0]    out_rd_q, out_rd_d;
  logic          out_regwrite_q, out_regwrite_d;
  logic          adel_q, adel_d;
  logic          ades_q, ades_d;
  logic          buserr_q, buserr_d;
  logic [31:0]   badvaddr_q, badvaddr_d;

  logic          is_load, is_store, is_mem, misaligned, flag_mis, timeout;
  logic [1:0]    in_size;
  logic [31:0]   addr_al, wdata_fmt, load_data;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    in_size  = 2'd0;
    case (in_op)
      EXE_LB_OP, EXE_LBU_OP: begin is_load  = 1'b1; in_size = 2'd0; end
      EXE_LH_OP, EXE_LHU_OP: begin is_load  = 1'b1; in_size = 2'd1; end
      EXE_LW_OP:             begin is_load  = 1'b1; in_size = 2'd2; end
      EXE_SB_OP:             begin is_store = 1'b1; in_size = 2'd0; end
      EXE_SH_OP:             begin is_store = 1'b1; in_size = 2'd1; end
      EXE_SW_OP:             begin is_store = 1'b1; in_size = 2'd2; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = ((in_size == 2'd1) && in_addr[0]) ||
                      ((in_size == 2'd2) && (in_addr[1:0] != 2'b00));
  assign flag_mis   = (CHECK_ALIGN != 0) && is_mem && misaligned;
  assign timeout    = (MAX_WAIT > 0) && (cnt_q == CNT_LIMIT);

  // With alignment checking off, misaligned addresses are silently rounded down.
  always_comb begin
    addr_al = in_addr;
    if (CHECK_ALIGN == 0) begin
      if (in_size == 2'd2)      addr_al = {in_addr[31:2], 2'b00};
      else if (in_size == 2'd1) addr_al = {in_addr[31:1], 1'b0};
    end
    case (in_size)
      2'd0:    wdata_fmt = {4{in_wdata[7:0]}};
      2'd1:    wdata_fmt = {2{in_wdata[15:0]}};
      default: wdata_fmt = in_wdata;
    endcase
  end

  always_comb begin
    case (data_addr_q[1:0])
      2'd0:    lane_b = data_rdata[7:0];
      2'd1:    lane_b = data_rdata[15:8];
      2'd2:    lane_b = data_rdata[23:16];
      default: lane_b = data_rdata[31:24];
    endcase
    lane_h = data_addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_q)
      EXE_LB_OP:  load_data = {{24{lane_b[7]}}, lane_b};
      EXE_LBU_OP: load_data = {24'd0, lane_b};
      EXE_LH_OP:  load_data = {{16{lane_h[15]}}, lane_h};
      EXE_LHU_OP: load_data = {16'd0, lane_h};
      EXE_LW_OP:  load_data = data_rdata;
      default:    load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    rd_d           = rd_q;
    regwrite_d     = regwrite_q;
    data_req_d     = data_req_q;
    data_wr_d      = data_wr_q;
    data_size_d    = data_size_q;
    data_addr_d    = data_addr_q;
    data_wdata_d   = data_wdata_q;
    out_valid_d    = 1'b0;
    out_rdata_d    = 32'd0;
    out_rd_d       = 5'd0;
    out_regwrite_d = 1'b0;
    adel_d         = 1'b0;
    ades_d         = 1'b0;
    buserr_d       = 1'b0;
    badvaddr_d     = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          if (flag_mis) begin
            out_valid_d = 1'b1;
            adel_d      = is_load;
            ades_d      = is_store;
            badvaddr_d  = in_addr;
          end else if (!is_mem) begin
            out_valid_d    = 1'b1;
            out_rd_d       = in_rd;
            out_regwrite_d = in_regwrite;
          end else begin
            state_d      = S_REQ;
            cnt_d        = '0;
            op_d         = in_op;
            rd_d         = in_rd;
            regwrite_d   = in_regwrite;
            data_req_d   = 1'b1;
            data_wr_d    = is_store;
            data_size_d  = in_size;
            data_addr_d  = addr_al;
            data_wdata_d = wdata_fmt;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          data_req_d = 1'b0;
          // An accepted-but-unfinished transfer must still be drained.
          state_d    = (data_addr_ok && !data_data_ok) ? S_DISCARD : S_IDLE;
        end else if (data_addr_ok && data_data_ok) begin
          data_req_d     = 1'b0;
          state_d        = S_IDLE;
          out_valid_d    = 1'b1;
          out_rdata_d    = load_data;
          out_rd_d       = rd_q;
          out_regwrite_d = regwrite_q;
        end else if (timeout) begin
          data_req_d  = 1'b0;
          state_d     = data_addr_ok ? S_DISCARD : S_IDLE;
          out_valid_d = 1'b1;
          buserr_d    = 1'b1;
          badvaddr_d  = data_addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (data_addr_ok) begin
            data_req_d = 1'b0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = data_data_ok ? S_IDLE : S_DISCARD;
        end else if (data_data_ok) begin
          state_d        = S_IDLE;
          out_valid_d    = 1'b1;
          out_rdata_d    = load_data;
          out_rd_d       = rd_q;
          out_regwrite_d = regwrite_q;
        end else if (timeout) begin
          state_d     = S_DISCARD;
          out_valid_d = 1'b1;
          buserr_d    = 1'b1;
          badvaddr_d  = data_addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (data_data_ok) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      op_q           <= 8'd0;
      rd_q           <= 5'd0;
      regwrite_q     <= 1'b0;
      data_req_q     <= 1'b0;
      data_wr_q      <= 1'b0;
      data_size_q    <= 2'd0;
      data_addr_q    <= 32'd0;
      data_wdata_q   <= 32'd0;
      out_valid_q    <= 1'b0;
      out_rdata_q    <= 32'd0;
      out_rd_q       <= 5'd0;
      out_regwrite_q <= 1'b0;
      adel_q         <= 1'b0;
      ades_q         <= 1'b0;
      buserr_q       <= 1'b0;
      badvaddr_q     <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      rd_q           <= rd_d;
      regwrite_q     <= regwrite_d;
      data_req_q     <= data_req_d;
      data_wr_q      <= data_wr_d;
      data_size_q    <= data_size_d;
      data_addr_q    <= data_addr_d;
      data_wdata_q   <= data_wdata_d;
      out_valid_q    <= out_valid_d;
      out_rdata_q    <= out_rdata_d;
      out_rd_q       <= out_rd_d;
      out_regwrite_q <= out_regwrite_d;
      adel_q         <= adel_d;
      ades_q         <= ades_d;
      buserr_q       <= buserr_d;
      badvaddr_q     <= badvaddr_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign data_req     = data_req_q;
  assign data_wr      = data_wr_q;
  assign data_size    = data_size_q;
  assign data_addr    = data_addr_q;
  assign data_wdata   = data_wdata_q;
  assign out_valid    = out_valid_q;
  assign out_rdata    = out_rdata_q;
  assign out_rd       = out_rd_q;
  assign out_regwrite = out_regwrite_q;
  assign adel         = adel_q;
  assign ades         = ades_q;
  assign buserr       = buserr_q;
  assign badvaddr     = badvaddr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single-beat ops plus
// hand-written multi-cycle sequences (slow bus, flush, watchdog, async reset).
module tb_mem_access_unit;

  localparam int W = 41;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [7:0] EXE_ADD_OP = 8'b00100000;

  localparam logic [1:0] K_BUS  = 2'd0;
  localparam logic [1:0] K_ADEL = 2'd1;
  localparam logic [1:0] K_ADES = 2'd2;
  localparam logic [1:0] K_NMEM = 2'd3;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  kind;
    logic        rw;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk, rst;
  logic        in_valid, in_ready, in_regwrite, flush;
  logic [7:0]  in_op;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        out_valid, out_regwrite, adel, ades, buserr;
  logic [31:0] out_rdata, badvaddr;
  logic [4:0]  out_rd;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[12];

  mem_access_unit #(.CHECK_ALIGN(1), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .adel(adel), .ades(ades),
    .buserr(buserr), .badvaddr(badvaddr), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_res(input logic a_l, input logic a_s, input logic b_e,
                                            input logic rw, input logic [4:0] rd,
                                            input logic [31:0] rdata);
    return {a_l, a_s, b_e, rw, rd, rdata};
  endfunction

  // Scoreboard: every out_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      logic [W-1:0] got, e;
      got = {adel, ades, buserr, out_regwrite, out_rd, out_rdata};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: got result 0x%011h expected no result", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL result: got 0x%011h expected 0x%011h", got, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_rd = rd; in_regwrite = rw;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    case (v.kind)
      K_BUS:   exp_q.push_back(pack_res(1'b0, 1'b0, 1'b0, v.rw, 5'd7, v.exp_rdata));
      K_ADEL:  exp_q.push_back(pack_res(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
      K_ADES:  exp_q.push_back(pack_res(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0));
      default: exp_q.push_back(pack_res(1'b0, 1'b0, 1'b0, v.rw, 5'd7, 32'd0));
    endcase
    accept(v.op, v.addr, v.wdata, 5'd7, v.rw);
    if (v.kind == K_BUS) begin
      check({tag, "_req"}, data_req, 1);
      check({tag, "_wr"}, data_wr, v.exp_wr);
      check({tag, "_size"}, data_size, v.exp_size);
      check({tag, "_addr"}, data_addr, v.addr);
      if (v.exp_wr) check({tag, "_wdata"}, data_wdata, v.exp_wdata);
      check({tag, "_in_ready_busy"}, in_ready, 0);
      check({tag, "_early_valid"}, out_valid, 0);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = v.rdata;
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_req_drop"}, data_req, 0);
    end else begin
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_no_req"}, data_req, 0);
      if (v.kind != K_NMEM) check({tag, "_badvaddr"}, badvaddr, v.addr);
    end
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    vecs[0]  = '{EXE_LW_OP,  32'h100, 32'h0,        32'h8899AABB, K_BUS,  1'b1, 1'b0, 2'd2, 32'h0,        32'h8899AABB};
    vecs[1]  = '{EXE_LB_OP,  32'h103, 32'h0,        32'h80FF0000, K_BUS,  1'b1, 1'b0, 2'd0, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{EXE_LBU_OP, 32'h103, 32'h0,        32'h80FF0000, K_BUS,  1'b1, 1'b0, 2'd0, 32'h0,        32'h00000080};
    vecs[3]  = '{EXE_SB_OP,  32'h102, 32'h12345678, 32'h0,        K_BUS,  1'b0, 1'b1, 2'd0, 32'h78787878, 32'h0};
    vecs[4]  = '{EXE_LH_OP,  32'h101, 32'h0,        32'h0,        K_ADEL, 1'b1, 1'b0, 2'd1, 32'h0,        32'h0};
    vecs[5]  = '{EXE_SW_OP,  32'h102, 32'h55AA55AA, 32'h0,        K_ADES, 1'b0, 1'b1, 2'd2, 32'h0,        32'h0};
    vecs[6]  = '{EXE_LH_OP,  32'h102, 32'h0,        32'h80011234, K_BUS,  1'b1, 1'b0, 2'd1, 32'h0,        32'hFFFF8001};
    vecs[7]  = '{EXE_LHU_OP, 32'h100, 32'h0,        32'h8001F234, K_BUS,  1'b1, 1'b0, 2'd1, 32'h0,        32'h0000F234};
    vecs[8]  = '{EXE_SH_OP,  32'h106, 32'hDEADBEEF, 32'h0,        K_BUS,  1'b0, 1'b1, 2'd1, 32'hBEEFBEEF, 32'h0};
    vecs[9]  = '{EXE_SW_OP,  32'h108, 32'hCAFEF00D, 32'h0,        K_BUS,  1'b0, 1'b1, 2'd2, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{EXE_LB_OP,  32'h101, 32'h0,        32'h12347F56, K_BUS,  1'b1, 1'b0, 2'd0, 32'h0,        32'h0000007F};
    vecs[11] = '{EXE_ADD_OP, 32'h0,   32'h0,        32'h0,        K_NMEM, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0};

    rst = 1'b0; in_valid = 1'b0; in_op = 8'd0; in_addr = 32'd0; in_wdata = 32'd0;
    in_rd = 5'd0; in_regwrite = 1'b0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_req", data_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_state", dbg_state, 0);
    check("rst_badvaddr", badvaddr, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 12; i++) do_vec(vecs[i], i);

    // Slow store: addr_ok on the 4th req cycle, data_ok 4 cycles later (the watchdog limit cycle).
    exp_q.push_back(pack_res(1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'd0));
    accept(EXE_SW_OP, 32'h200, 32'h11223344, 5'd7, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      check("slow_in_ready", in_ready, 0);
      check("slow_no_valid", out_valid, 0);
      check("slow_req", data_req, (c <= 4));
      if (c <= 4) check("slow_addr_stable", data_addr, 32'h200);
      data_addr_ok = (c == 4);
      data_data_ok = (c == 8);
      step();
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    check("slow_valid", out_valid, 1);
    check("slow_ready_back", in_ready, 1);
    step();
    check("slow_single_pulse", out_valid, 0);

    // Flush while waiting for data; data_ok two cycles after the flush is swallowed.
    accept(EXE_LW_OP, 32'h300, 32'h0, 5'd7, 1'b1);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    check("fl_wait_state", dbg_state, 2);
    check("fl_wait_req", data_req, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_discard_state", dbg_state, 3);
    check("fl_discard_ready", in_ready, 0);
    step();
    data_data_ok = 1'b1; data_rdata = 32'hDEADDEAD;
    step();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    check("fl_idle_state", dbg_state, 0);
    check("fl_idle_ready", in_ready, 1);
    check("fl_no_valid", out_valid, 0);
    do_vec(vecs[0], 100);

    // Flush in REQ before addr_ok drops the request immediately.
    accept(EXE_LW_OP, 32'h304, 32'h0, 5'd7, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flreq_req", data_req, 0);
    check("flreq_ready", in_ready, 1);

    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; flush = 1'b1; in_op = EXE_LW_OP; in_addr = 32'h308;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flidle_req", data_req, 0);
    check("flidle_state", dbg_state, 0);

    // Watchdog: addr_ok never comes.
    exp_q.push_back(pack_res(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0));
    accept(EXE_LW_OP, 32'h400, 32'h0, 5'd7, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      check("wd_req_held", data_req, 1);
      check("wd_no_valid", out_valid, 0);
      step();
    end
    check("wd_valid", out_valid, 1);
    check("wd_buserr", buserr, 1);
    check("wd_badvaddr", badvaddr, 32'h400);
    check("wd_req_drop", data_req, 0);
    check("wd_ready", in_ready, 1);
    step();

    // Asynchronous reset in the middle of WAIT.
    accept(EXE_SB_OP, 32'h501, 32'h000000AB, 5'd7, 1'b0);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    check("ar_wait_state", dbg_state, 2);
    check("ar_wdata_before", data_wdata, 32'hABABABAB);
    #2 rst = 1'b0;
    #1;
    check("ar_state", dbg_state, 0);
    check("ar_ready", in_ready, 1);
    check("ar_addr", data_addr, 0);
    check("ar_wdata", data_wdata, 0);
    check("ar_wr", data_wr, 0);
    check("ar_valid", out_valid, 0);
    step();
    rst = 1'b1;
    step(); step();

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage for the five-stage MIPS pipeline. It replaces the fixed single-cycle SRAM port with a stallable unit that drives an SRAM-like request/acknowledge bus (`req`/`addr_ok`/`data_ok`). For every memory op it formats store data, sign- or zero-extends load data, and flags misaligned addresses. It holds the pipeline through variable bus latency, supports an exception flush, and can time out a stuck access.

## Interface
- `CHECK_ALIGN`, 1: 1 = detect misaligned LH/LHU/LW/SH/SW (AdEL/AdES); 0 = force the low address bits to alignment and never flag.
- `MAX_WAIT`, 0: watchdog limit in cycles from request launch; 0 disables the watchdog.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: op present from EX/MEM.
- `in_ready` out 1: unit can accept an op; the pipeline stalls EX and earlier when this is low.
- `in_op` in 8: alucontrol code (`EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP` from defines2.vh).
- `in_addr` in 32: effective address.
- `in_wdata` in 32: forwarded rt value.
- `in_rd` in 5: destination register.
- `in_regwrite` in 1: op writes the register file.
- `flush` in 1: exception flush; kills the op in flight.
- `data_req`, `data_wr` out 1 each: bus request; write enable.
- `data_size` out 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` out 32: bus address.
- `data_wdata` out 32: replicated store data.
- `data_addr_ok`, `data_data_ok` in 1 each: address accepted; data done.
- `data_rdata` in 32: raw read word.
- `out_valid` out 1: one-cycle result pulse to MEM/WB.
- `out_rdata` out 32: extended load data (0 for stores and errors).
- `out_rd` out 5, `out_regwrite` out 1: destination register and write enable, cleared on error.
- `adel`, `ades`, `buserr` out 1 each: address-error-load, address-error-store, timeout.
- `badvaddr` out 32: faulting address.

## Operation
- States: IDLE, REQ, WAIT, DISCARD.
- `in_ready` = 1 only in IDLE.
- **Accept** (IDLE, `in_valid`, no `flush`): latch op, addr, data, rd and regwrite.
  - Misaligned (half with addr[0] set, word with addr[1:0] ≠ 0) and `CHECK_ALIGN` = 1: no bus activity; next cycle `out_valid` = 1 with `adel` (load) or `ades` (store) and `badvaddr` = addr; stay IDLE.
  - Non-memory op: `out_valid` next cycle, `out_rdata` = 0; stay IDLE.
  - Otherwise go to REQ.
- **REQ**: `data_req` = 1; addr/size/wr/wdata are stable.
  - Word store: wdata as is. Half store: {2{wdata[15:0]}}. Byte store: {4{wdata[7:0]}}.
  - `addr_ok` with `data_ok` in the same cycle → complete. `addr_ok` alone → WAIT.
- **WAIT**: `data_req` = 0; `data_ok` → complete.
- **Complete**: register the result and pulse `out_valid` next cycle; return to IDLE.
  - Load lane is selected by addr[1:0]: LH/LHU use bit 1, LB/LBU use bits 1:0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Flush**:
  - In IDLE: blocks acceptance.
  - In REQ before `addr_ok`: drop `req` and go to IDLE.
  - In REQ with `addr_ok` that cycle, or in WAIT: go to DISCARD.
  - DISCARD waits for `data_ok` and drops it; no `out_valid` for flushed ops.
- **Watchdog** (`MAX_WAIT` > 0): the counter clears on entering REQ and increments in REQ/WAIT.
  - On reaching `MAX_WAIT`: `out_valid` with `buserr` = 1 and `badvaddr` = addr.
  - From REQ (no `addr_ok`), go to IDLE. From WAIT, go to DISCARD.
  - Completion in the limit cycle wins over timeout.
- **Mid-operation reset**: all state is dropped immediately; the bus side is expected to be reset together with the unit.

## Timing
- Reset values: state IDLE; `in_ready` = 1; all other outputs 0.
- Latency is measured from the accept edge T.
- Error or non-memory op: `out_valid` at T+1.
- Bus op: `req` high from T+1.
- With `addr_ok` and `data_ok` both at cycle T+1+k: `out_valid` at T+2+k. Minimum accept-to-result is 2 cycles.
- Back-to-back: the next accept can happen in the `out_valid` cycle, so throughput is one op per (bus latency + 1) cycles.
- `data_*` outputs are registered and held constant while `req` is high.

## Test plan
- LW at 0x100; `addr_ok` and `data_ok` the cycle after `req`; rdata 0x8899AABB → `out_rdata` = 0x8899AABB, `out_valid` 2 cycles after accept, `data_size` = 2.
- LB addr 0x103 with rdata 0x80FF0000, then LBU at the same address → 0xFFFFFF80, then 0x00000080. SB addr 0x102 with wdata 0x12345678 → `data_wdata` = 0x78787878, `data_size` = 0.
- LH at 0x101 → `adel` = 1, `badvaddr` = 0x101, no `data_req`, `out_regwrite` = 0. SW at 0x102 → `ades` = 1.
- SW with `addr_ok` after 3 cycles and `data_ok` 4 cycles later → `in_ready` low throughout, exactly one `out_valid`, `req` low once the address is accepted.
- Flush in WAIT, `data_ok` 2 cycles later → no `out_valid`, IDLE after `data_ok`. Then a new LW completes normally.
- `MAX_WAIT` = 8 with `addr_ok` never asserted → `buserr` pulse 8 cycles after `req` rises, `req` drops, `in_ready` = 1. Assert `rst` low mid-WAIT → all outputs 0 asynchronously.
